hdr_rxdec: RTL



---
 rtl/hdr_rxdec_if.sv | 33 +++
 rtl/hdr_rxdec.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/hdr_rxdec_if.sv
// Signal bundle between the bit slicer / link controller and the header decoder.
// The master drives seeds and the sample stream; the slave returns the decoded header.
interface hdr_rxdec_if;
    logic       hdr_st_p;
    logic       rx_abort;
    logic       bit_valid_p;
    logic       rxbit;
    logic [7:0] hec_ini;
    logic [6:0] whiten_ini;
    logic       whiten_en;

    logic       hdr_busy;
    logic       hdr_done_p;
    logic [2:0] hdr_lt_addr;
    logic [3:0] hdr_type;
    logic       hdr_flow;
    logic       hdr_arqn;
    logic       hdr_seqn;
    logic       hdr_hecgood;
    logic [4:0] fec13_errcnt;

    modport master (
        output hdr_st_p, rx_abort, bit_valid_p, rxbit, hec_ini, whiten_ini, whiten_en,
        input  hdr_busy, hdr_done_p, hdr_lt_addr, hdr_type, hdr_flow, hdr_arqn,
               hdr_seqn, hdr_hecgood, fec13_errcnt
    );

    modport slave (
        input  hdr_st_p, rx_abort, bit_valid_p, rxbit, hec_ini, whiten_ini, whiten_en,
        output hdr_busy, hdr_done_p, hdr_lt_addr, hdr_type, hdr_flow, hdr_arqn,
               hdr_seqn, hdr_hecgood, fec13_errcnt
    );
endinterface

// File: rtl/hdr_rxdec.sv
// Packet-header receive decoder: FEC-1/3 majority vote, de-whitening, HEC check
// and field latching for the link controller.
module hdr_rxdec #(
    parameter int NSAMP = 54
) (
    input  logic         clk_6M,
    input  logic         rst,
    hdr_rxdec_if.slave   bus
);
    localparam int         NBITS    = NSAMP / 3;
    localparam logic [4:0] LAST_IDX = 5'(NBITS - 1);
    localparam logic [7:0] HEC_POLY = 8'hA7;

    typedef enum logic [1:0] {S_IDLE, S_RX, S_DONE} state_t;

    state_t     state_q, state_d;
    logic [1:0] rep_q, rep_d;
    logic [4:0] idx_q, idx_d;
    logic       s0_q, s0_d;
    logic       s1_q, s1_d;
    logic [7:0] hec_q, hec_d;
    logic [6:0] wl_q, wl_d;
    logic [9:0] fld_q, fld_d;
    logic [4:0] err_q, err_d;
    logic       latch_d;

    logic [2:0] lt_q;
    logic [3:0] type_q;
    logic       flow_q, arqn_q, seqn_q, hecgood_q;
    logic [4:0] errcnt_q;

    logic       maj, disagree, dbit, hec_fb;
    logic [7:0] hec_step;
    logic [6:0] wl_step;

    // Triple decode is evaluated against the live sample so the third sample
    // never needs its own storage slot.
    assign maj      = (s0_q & s1_q) | (s0_q & bus.rxbit) | (s1_q & bus.rxbit);
    assign disagree = !((s0_q == s1_q) && (s1_q == bus.rxbit));
    assign dbit     = maj ^ (bus.whiten_en & wl_q[6]);
    assign hec_fb   = hec_q[7] ^ dbit;

    assign hec_step[0] = hec_fb;
    genvar gi;
    generate
        for (gi = 1; gi < 8; gi++) begin : g_hec
            assign hec_step[gi] = hec_q[gi-1] ^ (HEC_POLY[gi] & hec_fb);
        end
    endgenerate

    assign wl_step = {wl_q[5], wl_q[4], wl_q[3] ^ wl_q[6], wl_q[2], wl_q[1], wl_q[0], wl_q[6]};

    always_comb begin
        state_d = state_q;
        rep_d   = rep_q;
        idx_d   = idx_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        hec_d   = hec_q;
        wl_d    = wl_q;
        fld_d   = fld_q;
        err_d   = err_q;
        latch_d = 1'b0;

        if (bus.hdr_st_p) begin
            state_d = S_RX;
            hec_d   = bus.hec_ini;
            wl_d    = bus.whiten_ini;
            rep_d   = 2'd0;
            idx_d   = 5'd0;
            err_d   = 5'd0;
            fld_d   = 10'd0;
        end else begin
            case (state_q)
                S_RX: begin
                    if (bus.rx_abort) begin
                        state_d = S_IDLE;
                    end else if (bus.bit_valid_p) begin
                        if (rep_q == 2'd0) begin
                            s0_d  = bus.rxbit;
                            rep_d = 2'd1;
                        end else if (rep_q == 2'd1) begin
                            s1_d  = bus.rxbit;
                            rep_d = 2'd2;
                        end else begin
                            rep_d = 2'd0;
                            idx_d = idx_q + 5'd1;
                            hec_d = hec_step;
                            wl_d  = wl_step;
                            if (disagree && (err_q != 5'd31)) begin
                                err_d = err_q + 5'd1;
                            end
                            // Only the ten field bits are kept; HEC bits just feed the LFSR.
                            if (idx_q < 5'd10) begin
                                fld_d = {dbit, fld_q[9:1]};
                            end
                            if (idx_q == LAST_IDX) begin
                                state_d = S_DONE;
                                latch_d = 1'b1;
                            end
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_6M) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rep_q     <= 2'd0;
            idx_q     <= 5'd0;
            s0_q      <= 1'b0;
            s1_q      <= 1'b0;
            hec_q     <= 8'd0;
            wl_q      <= 7'd0;
            fld_q     <= 10'd0;
            err_q     <= 5'd0;
            lt_q      <= 3'd0;
            type_q    <= 4'd0;
            flow_q    <= 1'b0;
            arqn_q    <= 1'b0;
            seqn_q    <= 1'b0;
            hecgood_q <= 1'b0;
            errcnt_q  <= 5'd0;
        end else begin
            state_q <= state_d;
            rep_q   <= rep_d;
            idx_q   <= idx_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            hec_q   <= hec_d;
            wl_q    <= wl_d;
            fld_q   <= fld_d;
            err_q   <= err_d;
            // Results are taken from next-state values so they are visible in the DONE cycle.
            if (latch_d) begin
                lt_q      <= fld_d[2:0];
                type_q    <= fld_d[6:3];
                flow_q    <= fld_d[7];
                arqn_q    <= fld_d[8];
                seqn_q    <= fld_d[9];
                hecgood_q <= (hec_d == 8'h00);
                errcnt_q  <= err_d;
            end
        end
    end

    assign bus.hdr_busy     = (state_q == S_RX);
    assign bus.hdr_done_p   = (state_q == S_DONE);
    assign bus.hdr_lt_addr  = lt_q;
    assign bus.hdr_type     = type_q;
    assign bus.hdr_flow     = flow_q;
    assign bus.hdr_arqn     = arqn_q;
    assign bus.hdr_seqn     = seqn_q;
    assign bus.hdr_hecgood  = hecgood_q;
    assign bus.fec13_errcnt = errcnt_q;
endmodule
